subtractor_4bit: RTL and testbench

- Registered ripple-borrow binary subtractor: computes D = A − B − Bin and Bout for WIDTH-bit unsigned operands; WIDTH defaults to 4.
- Used as a datapath leaf wherever a clocked subtract-with-borrow stage is needed.
- Bin/Bout allow cascading several instances into wider subtractors.

---
 rtl/subtractor_4bit_pkg.sv | 17 +
 rtl/subtractor_4bit_if.sv | 35 +++
 rtl/subtractor_4bit_full_subtractor.sv | 16 +
 rtl/subtractor_4bit.sv | 61 ++++++
 tb/tb_subtractor_4bit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/subtractor_4bit_pkg.sv
// Purpose: shared constants and result-register types for the registered subtractor.
// Latency: n/a (types only).
// Backpressure: n/a. Optional field ovf exists only when SUB_OVF_EN is defined.
package sub_pkg;

   localparam int SUB_WIDTH_DEFAULT = 4;

   // The flag bits of the result register.
   // d sits beside these in the top because its width follows WIDTH.
   typedef struct packed {
      logic bout;
`ifdef SUB_OVF_EN
      logic ovf;
`endif
   } sub_flags_t;

endpackage

// File: rtl/subtractor_4bit_if.sv
// Purpose: operand/result bundle for subtractor_4bit (master drives operands, slave returns results).
// Latency: n/a (wiring only).
// Backpressure: none; in_valid/out_valid are qualifiers only. ovf exists only with SUB_OVF_EN.
interface subtractor_4bit_if #(
   parameter int WIDTH = sub_pkg::SUB_WIDTH_DEFAULT
) ();

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             out_valid;
`ifdef SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, bin,
      input  d, bout, out_valid
`ifdef SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, bin,
      output d, bout, out_valid
`ifdef SUB_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/subtractor_4bit_full_subtractor.sv
// Purpose: one-bit full subtractor cell (d = a - b - bin, bout = borrow out).
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow toward the next more-significant stage.
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_4bit.sv
// Purpose: registered ripple-borrow subtractor {bout,d} = a - b - bin; ovf port only with SUB_OVF_EN.
// Latency: 1 cycle from in_valid edge to out_valid; results hold while in_valid is low.
// Backpressure: none; one result per cycle, out_valid is a one-cycle qualifier.
module subtractor_4bit
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
   input logic              clk,
   input logic              rst_n,
   subtractor_4bit_if.slave bus
);

   // br[i] is the borrow into stage i; br[0] is the external borrow-in.
   logic [WIDTH:0]   br;
   logic [WIDTH-1:0] d_c;

   logic [WIDTH-1:0] d_q;
   sub_flags_t       flg_q;
   logic             vld_q;

   assign br[0] = bus.bin;

   // Ripple chain of one-bit cells, LSB first.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_subtractor u_fs (
         .a    (bus.a[i]),
         .b    (bus.b[i]),
         .bin  (br[i]),
         .d    (d_c[i]),
         .bout (br[i+1])
      );
   end

   // Result register: capture on in_valid, otherwise hold; reset wins over in_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_q   <= '0;
         flg_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            d_q        <= d_c;
            flg_q.bout <= br[WIDTH];
`ifdef SUB_OVF_EN
            // Signed overflow: borrow into and out of the sign stage disagree.
            flg_q.ovf  <= br[WIDTH] ^ br[WIDTH-1];
`endif
         end
      end
   end

   assign bus.d         = d_q;
   assign bus.bout      = flg_q.bout;
   assign bus.out_valid = vld_q;
`ifdef SUB_OVF_EN
   assign bus.ovf       = flg_q.ovf;
`endif

endmodule

// File: tb/tb_subtractor_4bit.sv
// Purpose: scoreboard bench for subtractor_4bit with randomized and directed operands.
// Latency: expects results one cycle after each accepted operand set.
// Backpressure: none; monitor pops the expected queue whenever out_valid is high.
module tb_subtractor_4bit;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;

   subtractor_4bit_if #(.WIDTH(W)) bus ();

   subtractor_4bit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t last_exp;
   logic exp_vld;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      exp_t r;
      int   u;
      int   s;
      int   sa;
      int   sb;
      u = int'(a) - int'(b) - int'(bin);
      // Modulo 2^(W+1), kept non-negative.
      u = (u + (1 << (W + 1))) % (1 << (W + 1));
      r.d    = W'(u % (1 << W));
      r.bout = (u >= (1 << W));
      sa = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
      sb = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
      s  = sa - sb - int'(bin);
      r.ovf = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
      return r;
   endfunction

   // Expected-behaviour tracker: what the outputs must show after each edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_vld  <= 1'b0;
         last_exp <= '0;
      end else begin
         exp_vld <= bus.in_valid;
         if (bus.in_valid) begin
            last_exp <= model(bus.a, bus.b, bus.bin);
            exp_q.push_back(model(bus.a, bus.b, bus.bin));
         end
      end
   end

   // Monitor: compare on the falling edge, away from the capture edge.
   always @(negedge clk) begin
      exp_t e;
      n_chk++;
      if (bus.out_valid !== exp_vld) begin
         n_fail++;
         $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, exp_vld, $time);
      end
      n_chk++;
      if (bus.d !== last_exp.d || bus.bout !== last_exp.bout) begin
         n_fail++;
         $display("FAIL held_result: got d=%b bout=%b want d=%b bout=%b at %0t",
                  bus.d, bus.bout, last_exp.d, last_exp.bout, $time);
      end
`ifdef SUB_OVF_EN
      n_chk++;
      if (bus.ovf !== last_exp.ovf) begin
         n_fail++;
         $display("FAIL ovf: got %b want %b at %0t", bus.ovf, last_exp.ovf, $time);
      end
`endif
      if (bus.out_valid === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got out_valid=1 want no result at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            if (bus.d !== e.d || bus.bout !== e.bout) begin
               n_fail++;
               $display("FAIL scoreboard: got d=%b bout=%b want d=%b bout=%b at %0t",
                        bus.d, bus.bout, e.d, e.bout, $time);
            end
         end
      end
   end

   // Drive one cycle of stimulus just after a rising edge.
   task automatic drive(input logic rst, input logic v,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      @(posedge clk);
      #1;
      rst_n        = rst;
      bus.in_valid = v;
      bus.a        = a;
      bus.b        = b;
      bus.bin      = bin;
   endtask

   task automatic drive_idle();
      drive(1'b1, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.bin      = 1'($urandom);

      // Reset with in_valid high: operands must be discarded.
      drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));

      // Directed vectors, including borrow and equal-operand boundaries.
      drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
      drive(1'b1, 1'b1, 4'b0001, 4'b0010, 1'b1);
      drive(1'b1, 1'b1, 4'b1100, 4'b1110, 1'b0);
      drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      drive(1'b1, 1'b1, 4'b0011, 4'b0000, 1'b1);
      drive(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
      drive(1'b1, 1'b1, 4'b1010, 4'b1010, 1'b1);
      // Signed-overflow vectors.
      drive(1'b1, 1'b1, 4'b1000, 4'b0001, 1'b0);
      drive(1'b1, 1'b1, 4'b0111, 4'b1111, 1'b0);
      drive(1'b1, 1'b1, 4'b0101, 4'b0011, 1'b0);

      // Hold: one valid result then idle cycles with changing operands.
      drive(1'b1, 1'b1, 4'b0011, 4'b0000, 1'b1);
      repeat (3) drive_idle();

      // Streaming: four back-to-back results.
      drive(1'b1, 1'b1, 4'b1001, 4'b0100, 1'b0);
      drive(1'b1, 1'b1, 4'b0010, 4'b0111, 1'b1);
      drive(1'b1, 1'b1, 4'b1111, 4'b0001, 1'b1);
      drive(1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0);
      drive_idle();

      // Randomized operands with random gaps.
      for (int i = 0; i < 200; i++) begin
         drive(1'b1, 1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
      end

      // Mid-run reset with a valid operand present.
      drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
      drive_idle();

      // Exhaustive sweep of every operand combination.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(i);
         drive(1'b1, 1'b1, v[8:5], v[4:1], v[0]);
      end
      repeat (3) drive_idle();

      @(posedge clk);
      #1;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d results outstanding want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
